signed_div_ctrl: RTL and testbench

SIGNED_DIV_CTRL -- requirements
Module: signed_div_ctrl

---
 rtl/signed_div_ctrl_if.sv | 37 +++
 rtl/signed_div_ctrl.sv | 162 ++++++++++++++++
 tb/tb_signed_div_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/signed_div_ctrl_if.sv
// ---------------------------------------------------------------------------
// signed_div_ctrl_if
// Bundles the request and result signals of the signed divider controller.
//   ctrl_div       : start request, one cycle, sampled on every rising edge
//   data_operandA  : 32-bit two's-complement dividend
//   data_operandB  : 32-bit two's-complement divisor
//   data_result    : 32-bit two's-complement quotient (truncated toward zero)
//   data_exception : divide-by-zero or overflow flag
//   data_resultRDY : one-cycle pulse, result and exception valid
// master modport: requester side.  slave modport: the divider.
// ---------------------------------------------------------------------------
interface signed_div_ctrl_if;
  logic        ctrl_div;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  modport master (
    output ctrl_div,
    output data_operandA,
    output data_operandB,
    input  data_result,
    input  data_exception,
    input  data_resultRDY
  );

  modport slave (
    input  ctrl_div,
    input  data_operandA,
    input  data_operandB,
    output data_result,
    output data_exception,
    output data_resultRDY
  );
endinterface

// File: rtl/signed_div_ctrl.sv
// ---------------------------------------------------------------------------
// signed_div_ctrl
// 32-bit signed divider using a restoring shift/subtract loop on magnitudes,
// one quotient bit per cycle, with sign fix-up at the end.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : signed_div_ctrl_if.slave (start request, operands, results)
// Sequence: capture -> PREP (1) -> ITER (32) -> FIX (1) -> DONE (1 pulse).
// Divide-by-zero skips straight from PREP to DONE.
// A start request in any state restarts with the new operands.
// ---------------------------------------------------------------------------
module signed_div_ctrl (
  input  logic             clock,
  input  logic             reset,
  signed_div_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_q,  state_d;
  logic [5:0]  cnt_q,    cnt_d;
  logic [31:0] a_q,      a_d;
  logic [31:0] b_q,      b_d;
  logic [31:0] b_mag_q,  b_mag_d;
  logic [32:0] rem_q,    rem_d;
  logic [31:0] quot_q,   quot_d;
  logic        sign_q,   sign_d;
  logic [31:0] result_q, result_d;
  logic        exc_q,    exc_d;
  logic        rdy_q,    rdy_d;

  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [32:0] shifted_s;
  logic [33:0] diff_s;

  // Magnitudes are unsigned, so 0x80000000 maps to 2^31 without overflow.
  assign a_mag_s = a_q[31] ? (~a_q + 32'd1) : a_q;
  assign b_mag_s = b_q[31] ? (~b_q + 32'd1) : b_q;

  // One restoring step: shift the next dividend bit into the remainder and
  // trial-subtract; bit 33 of the difference is the "negative trial" flag.
  assign shifted_s = {rem_q[31:0], quot_q[31]};
  assign diff_s    = {1'b0, shifted_s} - {2'b00, b_mag_q};

  // Next-state and datapath decisions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    b_mag_d  = b_mag_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    sign_d   = sign_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    if (bus.ctrl_div) begin
      // Restart wins over everything, including a pending DONE.
      state_d = PREP;
      a_d     = bus.data_operandA;
      b_d     = bus.data_operandB;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        PREP: begin
          sign_d  = a_q[31] ^ b_q[31];
          rem_d   = 33'd0;
          quot_d  = a_mag_s;
          b_mag_d = b_mag_s;
          cnt_d   = 6'd0;
          if (b_q == 32'd0) begin
            state_d  = DONE;
            result_d = 32'd0;
            exc_d    = 1'b1;
            rdy_d    = 1'b1;
          end else begin
            state_d = ITER;
          end
        end
        ITER: begin
          if (!diff_s[33]) begin
            rem_d  = diff_s[32:0];
            quot_d = {quot_q[30:0], 1'b1};
          end else begin
            rem_d  = shifted_s;
            quot_d = {quot_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d = FIX;
          end else begin
            state_d = ITER;
          end
        end
        FIX: begin
          // Only -2^31 / -1 yields a positive 2^31, which does not fit.
          if ((quot_q == 32'h8000_0000) && !sign_q) begin
            result_d = 32'h8000_0000;
            exc_d    = 1'b1;
          end else begin
            result_d = sign_q ? (~quot_q + 32'd1) : quot_q;
            exc_d    = 1'b0;
          end
          state_d = DONE;
          rdy_d   = 1'b1;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      b_mag_q  <= 32'd0;
      rem_q    <= 33'd0;
      quot_q   <= 32'd0;
      sign_q   <= 1'b0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      b_mag_q  <= b_mag_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;

endmodule

// File: tb/tb_signed_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_signed_div_ctrl
// Self-checking bench for signed_div_ctrl. Expected quotients come from
// 64-bit signed arithmetic; latencies come from the documented timing.
// ---------------------------------------------------------------------------
module tb_signed_div_ctrl;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] last_res;
  logic        last_exc;

  signed_div_ctrl_if bus();

  signed_div_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Reference: truncating signed division on 64-bit integers.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic e);
    longint sa, sb, sq;
    if (b == 32'd0) begin
      q = 32'd0;
      e = 1'b1;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      if (sq == 64'sd2147483648) begin
        q = 32'h8000_0000;
        e = 1'b1;
      end else begin
        q = sq[31:0];
        e = 1'b0;
      end
    end
  endfunction

  // Called at a negedge; request is captured by the next posedge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_div      = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clock);
    bus.ctrl_div      = 1'b0;
    bus.data_operandA = $urandom();
    bus.data_operandB = $urandom();
  endtask

  // n counts negedges after the capture edge; n = k+1 is the cycle after E0+k.
  task automatic wait_rdy(input int limit, output int lat, output logic [31:0] r,
                          output logic e, output logic held);
    lat  = -1;
    held = 1'b1;
    r    = 32'd0;
    e    = 1'b0;
    for (int n = 1; n <= limit; n++) begin
      if (bus.data_resultRDY === 1'b1) begin
        lat = n;
        r   = bus.data_result;
        e   = bus.data_exception;
        break;
      end
      if (bus.data_result !== last_res || bus.data_exception !== last_exc) held = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string name);
    logic [31:0] exp_q, got_q;
    logic        exp_e, got_e, held;
    int          lat, exp_lat;
    ref_div(a, b, exp_q, exp_e);
    exp_lat = (b == 32'd0) ? 2 : 35;
    start_op(a, b);
    wait_rdy(60, lat, got_q, got_e, held);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d (a=%h b=%h)", name, lat, exp_lat, a, b);
    end
    checks++;
    if (got_q !== exp_q) begin
      errors++;
      $display("FAIL %s result: got %h expected %h (a=%h b=%h)", name, got_q, exp_q, a, b);
    end
    checks++;
    if (got_e !== exp_e) begin
      errors++;
      $display("FAIL %s exception: got %b expected %b (a=%h b=%h)", name, got_e, exp_e, a, b);
    end
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL %s hold: outputs changed before ready (a=%h b=%h)", name, a, b);
    end
    last_res = exp_q;
    last_exc = exp_e;
    @(negedge clock);
    checks++;
    if (bus.data_resultRDY !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse: ready still %b one cycle later", name, bus.data_resultRDY);
    end
  endtask

  task automatic test_reset();
    bus.ctrl_div      = 1'b0;
    bus.data_operandA = 32'd0;
    bus.data_operandB = 32'd0;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.data_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_result: got %h expected 00000000", bus.data_result);
    end
    checks++;
    if (bus.data_exception !== 1'b0) begin
      errors++;
      $display("FAIL reset_exception: got %b expected 0", bus.data_exception);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (bus.data_resultRDY !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdy: got %b expected 0", bus.data_resultRDY);
    end
    reset    = 1'b0;
    last_res = 32'd0;
    last_exc = 1'b0;
  endtask

  task automatic test_directed();
    run_op(32'd100,        32'd7,          "pos_div");
    run_op(32'hFFFF_FF9C,  32'd7,          "neg_dividend");
    run_op(32'hFFFF_FFF9,  32'hFFFF_FFFE,  "both_neg");
    run_op(32'd5,          32'd0,          "div_zero");
    run_op(32'h8000_0000,  32'hFFFF_FFFF,  "overflow");
    run_op(32'h8000_0000,  32'd1,          "min_by_one");
    run_op(32'd0,          32'd5,          "zero_dividend");
    run_op(32'd1,          32'hFFFF_FFFE,  "neg_zero_quot");
    run_op(32'hFFFF_FFFF,  32'h8000_0000,  "by_min");
    run_op(32'h7FFF_FFFF,  32'd1,          "max_by_one");
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      4:       return $urandom_range(0, 200) - 32'd100;
      default: return $urandom();
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_op(pick_operand(), pick_operand(), "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, exp_q;
    logic        e, held, exp_e;
    int          lat;
    start_op(32'd1000, 32'hFFFF_FFF6);
    wait_rdy(60, lat, r, e, held);
    ref_div(32'd1000, 32'hFFFF_FFF6, exp_q, exp_e);
    checks++;
    if (lat !== 35 || r !== exp_q) begin
      errors++;
      $display("FAIL b2b_first: lat %0d result %h expected lat 35 result %h", lat, r, exp_q);
    end
    last_res = exp_q;
    last_exc = exp_e;
    // New request issued during the DONE cycle.
    start_op(32'd77, 32'd11);
    wait_rdy(60, lat, r, e, held);
    checks++;
    if (lat !== 35 || r !== 32'd7 || e !== 1'b0 || held !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: lat %0d result %h exc %b held %b expected lat 35 result 00000007 exc 0 held 1",
               lat, r, e, held);
    end
    last_res = 32'd7;
    last_exc = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_restart();
    logic [31:0] r;
    logic        e, held;
    int          lat, early;
    early = 0;
    start_op(32'd100, 32'd7);
    for (int n = 1; n < 10; n++) begin
      if (bus.data_resultRDY === 1'b1) early++;
      @(negedge clock);
    end
    start_op(32'd9, 32'd3);
    wait_rdy(60, lat, r, e, held);
    checks++;
    if (early != 0 || lat !== 35) begin
      errors++;
      $display("FAIL restart_latency: early %0d lat %0d expected early 0 lat 35", early, lat);
    end
    checks++;
    if (r !== 32'd3 || e !== 1'b0 || held !== 1'b1) begin
      errors++;
      $display("FAIL restart_result: result %h exc %b held %b expected 00000003 0 1", r, e, held);
    end
    last_res = 32'd3;
    last_exc = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    start_op(32'd100, 32'd7);
    repeat (19) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.data_result !== 32'd0 || bus.data_exception !== 1'b0 || bus.data_resultRDY !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: result %h exc %b rdy %b expected 00000000 0 0",
               bus.data_result, bus.data_exception, bus.data_resultRDY);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (bus.data_resultRDY === 1'b1) pulses++;
      @(negedge clock);
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_mid_no_rdy: got %0d pulses expected 0", pulses);
    end
    last_res = 32'd0;
    last_exc = 1'b0;
    // Start request on the first edge after reset release.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    run_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
